ps2_transmitter: RTL

PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

---
 rtl/ps2_transmitter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device transmitter. The host inhibits the bus, sends a start
// bit, and then shifts out 8 data bits, odd parity and a stop bit on the
// device-generated clock. It then checks the device's ACK. Both bus lines are
// read back through a synchronizer and a glitch filter. The lines are driven
// as open-collector outputs: each *_oe output pulls its line low when set.

// One bus line: a 2-flop synchronizer followed by a stability filter. The
// filtered output takes a new level only after the synchronized level has held
// it for FILT consecutive cycles. The filter resets to the idle-bus level (1).
module ps2_line_filt #(
  parameter int FILT = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int FW = $clog2(FILT + 1);

  logic [1:0]    sync;
  logic [FW-1:0] cnt;

  // synchronize, then count cycles in which the synchronized level disagrees with dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == FW'(FILT - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + FW'(1);
      end
    end
  end
endmodule

module ps2_transmitter #(
  parameter int FILT        = 20,
  parameter int INHIBIT_CYC = 12000,   // must be >= 2
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclk,
  input  logic       kdata,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);
  localparam int NUM_LANES = 2;  // lane 0 = kclk, lane 1 = kdata
  localparam int CNT_MAX   = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW        = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  logic [NUM_LANES-1:0] line_raw, line_f, line_q;
  logic                 kclk_fall, kclk_edge, tmo;
  state_t               state;
  logic [CW-1:0]        cnt, cnt_inc;
  logic [9:0]           frame;   // {stop, parity, data}; index = falling edge number - 1
  logic [3:0]           bitn;

  assign line_raw = {kdata, kclk};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_line
      ps2_line_filt #(.FILT(FILT)) u_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (line_raw[g]),
        .dout (line_f[g])
      );
    end
  endgenerate

  // delayed copy of the filtered levels for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_q <= '1;
    else     line_q <= line_f;
  end

  assign kclk_fall = line_q[0] & ~line_f[0];
  assign kclk_edge = line_q[0] ^ line_f[0];
  assign cnt_inc   = (cnt == CW'(CNT_MAX)) ? cnt : cnt + CW'(1);
  // the count would reach TIMEOUT_CYC this cycle with no kclk edge to clear it
  assign tmo       = !kclk_edge && (cnt == CW'(TIMEOUT_CYC - 1));

  // transfer FSM: all outputs are registered, and done/err are single-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_ready <= 1'b1;
      kclk_oe  <= 1'b0;
      kdata_oe <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      cnt      <= '0;
      frame    <= '0;
      bitn     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            frame    <= {1'b1, ~^tx_data, tx_data};
            kclk_oe  <= 1'b1;
            cnt      <= '0;
            bitn     <= '0;
            tx_ready <= 1'b0;
            state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          // the start bit is set up one cycle before the clock is released
          if (cnt == CW'(INHIBIT_CYC - 2)) kdata_oe <= 1'b1;
          if (cnt == CW'(INHIBIT_CYC - 1)) begin
            kclk_oe <= 1'b0;
            cnt     <= '0;
            state   <= REQ;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REQ, SEND, ACK, WAIT_IDLE: begin
          cnt <= kclk_edge ? '0 : cnt_inc;
          if (state == WAIT_IDLE && line_f == 2'b11) begin
            done     <= 1'b1;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else if (tmo) begin
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b01;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else if (kclk_fall) begin
            if (state == REQ || state == SEND) begin
              // the falling edge that leaves REQ is edge 1 and presents data bit 0
              kdata_oe <= ~frame[bitn];
              bitn     <= bitn + 4'd1;
              state    <= (bitn == 4'd9) ? ACK : SEND;
            end else if (state == ACK) begin
              if (!line_f[1]) begin
                state <= WAIT_IDLE;
              end else begin
                kclk_oe  <= 1'b0;
                kdata_oe <= 1'b0;
                err      <= 1'b1;
                err_code <= 2'b10;
                tx_ready <= 1'b1;
                state    <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
